// File: rtl/dds_pkg.sv
// Shared definitions for the DDS block family: FSM encoding and default widths.
package dds_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int DDS_WIDTH_DEFAULT = 32;
    localparam int GATE_LOG2_DEFAULT = 16;

endpackage

// File: rtl/dds_edge_detect.sv
// Rising-edge detector with history register; optional 2-FF synchroniser when
// DDS_FREQ_METER_SYNC_EN is defined.
module dds_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sig_in,
    output logic rise
);

    logic sig_s;
    logic prev_q, prev_d;

`ifdef DDS_FREQ_METER_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sig_s = sync2_q;
`else
    assign sig_s = sig_in;
`endif

    // History tracks sig_s continuously, so the first counting cycle compares
    // against a real previous sample instead of a stale value.
    always_comb begin
        prev_d = sig_s;
    end

    always_ff @(posedge clk) begin
        if (reset) prev_q <= sig_s;
        else       prev_q <= prev_d;
    end

    assign rise = sig_s & ~prev_q & ~clear;

endmodule

// File: rtl/dds_freq_meter.sv
// Gated edge counter that converts a periodic input back into a DDS tuning word.
// Optional input synchroniser: define DDS_FREQ_METER_SYNC_EN.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int WIDTH     = DDS_WIDTH_DEFAULT,
    parameter int GATE_LOG2 = GATE_LOG2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [WIDTH-1:0]     freq_word,
    output logic [GATE_LOG2-1:0] edge_count,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun
);

    localparam int                   SHIFT   = WIDTH - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [GATE_LOG2-1:0] gate_q, gate_d;
    logic [GATE_LOG2-1:0] edge_q, edge_d;
    logic [GATE_LOG2-1:0] edge_count_q, edge_count_d;
    logic [WIDTH-1:0]     freq_word_q, freq_word_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic [GATE_LOG2-1:0] final_cnt;
    logic                 rise;

    dds_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == IDLE),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        edge_d       = edge_q;
        edge_count_d = edge_count_q;
        freq_word_d  = freq_word_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        // A rise on the terminal cycle still belongs to the closing gate.
        final_cnt    = (rise && (edge_q != CNT_MAX)) ? edge_q + GATE_LOG2'(1) : edge_q;

        if (valid_q && ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                gate_d = '0;
                edge_d = '0;
                if (enable) state_d = COUNT;
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                end else begin
                    gate_d = gate_q + GATE_LOG2'(1);
                    edge_d = final_cnt;
                    if (gate_q == CNT_MAX) begin
                        edge_d       = '0;
                        edge_count_d = final_cnt;
                        freq_word_d  = {final_cnt, {SHIFT{1'b0}}};
                        valid_d      = 1'b1;
                        if (valid_q && !ready) overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gate_q       <= '0;
            edge_q       <= '0;
            edge_count_q <= '0;
            freq_word_q  <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            edge_q       <= edge_d;
            edge_count_q <= edge_count_d;
            freq_word_q  <= freq_word_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign freq_word  = freq_word_q;
    assign edge_count = edge_count_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench: GATE_LOG2=8 instance for protocol scenarios, GATE_LOG2=16
// instance fed by a DDS model for the end-to-end frequency check.
module tb_dds_freq_meter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: short gate.
    logic        reset_a, enable_a, sig_a, ready_a;
    logic [31:0] freq_word_a;
    logic [7:0]  edge_count_a;
    logic        valid_a, overrun_a;

    dds_freq_meter #(.WIDTH(32), .GATE_LOG2(8)) dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .enable     (enable_a),
        .sig_in     (sig_a),
        .freq_word  (freq_word_a),
        .edge_count (edge_count_a),
        .valid      (valid_a),
        .ready      (ready_a),
        .overrun    (overrun_a)
    );

    // Instance B: default gate, driven by a DDS MSB.
    logic        reset_b, enable_b, sig_b, ready_b;
    logic [31:0] freq_word_b;
    logic [15:0] edge_count_b;
    logic        valid_b, overrun_b;

    dds_freq_meter #(.WIDTH(32), .GATE_LOG2(16)) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .enable     (enable_b),
        .sig_in     (sig_b),
        .freq_word  (freq_word_b),
        .edge_count (edge_count_b),
        .valid      (valid_b),
        .ready      (ready_b),
        .overrun    (overrun_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pattern for sig_a: 0 = const 0, 1 = const 1, 2 = period 4 (2 high / 2 low).
    int sig_mode = 1;
    initial begin
        int ph;
        ph    = 0;
        sig_a = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (sig_mode)
                0:       sig_a = 1'b0;
                1:       sig_a = 1'b1;
                default: sig_a = (ph % 4) < 2;
            endcase
            ph++;
        end
    end

    // DDS model: 32-bit accumulator, increment 33333333, MSB out.
    initial begin
        logic [31:0] phase;
        phase = '0;
        sig_b = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            sig_b = phase[31];
            phase = phase + 32'd33333333;
        end
    end

    task automatic reset_dut_a();
        reset_a  = 1'b1;
        enable_a = 1'b0;
        repeat (5) @(negedge clk);
        reset_a  = 1'b0;
    endtask

    // Counts negedges until valid_a is seen (at least one step), bounded by max.
    task automatic wait_valid_a(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_a && n < max);
    endtask

    task automatic run_protocol();
        int  n;
        bit  seen;

        // 1: reset with enable low, nothing ever becomes valid.
        ready_a  = 1'b1;
        sig_mode = 1;
        reset_dut_a();
        check("s1_valid",   valid_a,      1'b0);
        check("s1_overrun", overrun_a,    1'b0);
        check("s1_count",   edge_count_a, 8'd0);
        check("s1_freq",    freq_word_a,  32'd0);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (valid_a) seen = 1'b1;
        end
        check("s1_no_valid", seen, 1'b0);

        // 2: constant high -> zero edges, one valid per 256 clocks.
        // First result: 1 IDLE->COUNT cycle + 256 gate cycles after enable.
        reset_dut_a();
        enable_a = 1'b1;
        wait_valid_a(400, n);
        check("s2_first_lat", n, 257);
        check("s2_count0",    edge_count_a, 8'd0);
        check("s2_freq0",     freq_word_a,  32'd0);
        for (int g = 1; g < 3; g++) begin
            wait_valid_a(400, n);
            check("s2_period", n, 256);
            check("s2_count",  edge_count_a, 8'd0);
            check("s2_freq",   freq_word_a,  32'd0);
        end

        // 3: period-4 input -> 64 edges, tuning word 0x4000_0000 every gate.
        reset_dut_a();
        sig_mode = 2;
        enable_a = 1'b1;
        wait_valid_a(400, n);
        check("s3_first_lat", n, 257);
        check("s3_count0",    edge_count_a, 8'd64);
        check("s3_freq0",     freq_word_a,  32'h4000_0000);
        for (int g = 1; g < 3; g++) begin
            @(negedge clk);
            check("s3_pulse", valid_a, 1'b0);
            wait_valid_a(400, n);
            check("s3_period",  n, 255);
            check("s3_count",   edge_count_a, 8'd64);
            check("s3_freq",    freq_word_a,  32'h4000_0000);
            check("s3_overrun", overrun_a,    1'b0);
        end

        // 4: consumer stalls for two gates; second gate sees no edges.
        reset_dut_a();
        ready_a  = 1'b0;
        sig_mode = 2;
        enable_a = 1'b1;
        wait_valid_a(400, n);
        check("s4_count1",   edge_count_a, 8'd64);
        check("s4_overrun1", overrun_a,    1'b0);
        sig_mode = 0;
        repeat (100) @(negedge clk);
        check("s4_hold_valid", valid_a,      1'b1);
        check("s4_hold_count", edge_count_a, 8'd64);
        check("s4_hold_freq",  freq_word_a,  32'h4000_0000);
        repeat (156) @(negedge clk);
        check("s4_overrun2", overrun_a,    1'b1);
        check("s4_valid2",   valid_a,      1'b1);
        check("s4_count2",   edge_count_a, 8'd0);
        check("s4_freq2",    freq_word_a,  32'd0);
        enable_a = 1'b0;
        repeat (5) @(negedge clk);
        check("s4_keep_on_abort", valid_a, 1'b1);
        ready_a = 1'b1;
        @(negedge clk);
        check("s4_consumed",    valid_a,   1'b0);
        check("s4_sticky",      overrun_a, 1'b1);
        ready_a = 1'b0;
        repeat (3) @(negedge clk);
        check("s4_sticky_late", overrun_a, 1'b1);

        // 5: abort a gate at clock 100, then restart.
        reset_dut_a();
        ready_a  = 1'b1;
        sig_mode = 2;
        enable_a = 1'b1;
        repeat (101) @(negedge clk);
        enable_a = 1'b0;
        seen     = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid_a) seen = 1'b1;
        end
        check("s5_no_valid", seen, 1'b0);
        enable_a = 1'b1;
        wait_valid_a(400, n);
        check("s5_restart_lat", n, 257);
        check("s5_count",       edge_count_a, 8'd64);
        check("s5_freq",        freq_word_a,  32'h4000_0000);
    endtask

    task automatic run_dds_loop();
        int n;
        reset_b  = 1'b1;
        enable_b = 1'b0;
        ready_b  = 1'b1;
        repeat (5) @(negedge clk);
        reset_b  = 1'b0;
        enable_b = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_b && n < 70000);
        check("s6_valid", valid_b, 1'b1);
        // 65536 * 33333333 / 2^32 = 508.6 edges per gate.
        check("s6_count_range",
              (edge_count_b == 16'd508) || (edge_count_b == 16'd509), 1'b1);
        check("s6_freq_range",
              (freq_word_b == 32'd33292288) || (freq_word_b == 32'd33357824), 1'b1);
        check("s6_overrun", overrun_b, 1'b0);
    endtask

    initial begin
        reset_a  = 1'b1;
        enable_a = 1'b0;
        ready_a  = 1'b0;
        reset_b  = 1'b1;
        enable_b = 1'b0;
        ready_b  = 1'b0;
        fork
            run_protocol();
            run_dds_loop();
        join
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
